dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Initiator for the data-memory bank: converts one-at-a-time load/store requests from the CPU MEM stage into memread/memwrite strobes.
//  Handles byte/half/word access with sign/zero extension and read-modify-write for sub-word stores.
//  Memory-side ports connect directly to the bank (word-indexed, 128 words, strobe-level, one-step settle delay).
// PARAMETERS
//  DATA_W      32   data width; bank word width
//  DEPTH_WORDS 128  bank depth in words
//  MEM_LAT     1    extra cycles a strobe is held before data is sampled/committed (>=0)
// PORTS
//  clk         in   1   sole clock; all state on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   controller idle; request accepted when req_valid & req_ready
//  req_we      in   1   1=store, 0=load
//  req_size    in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1   load sign-extends when 1
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned
//  resp_valid  out  1   one-cycle completion pulse; no backpressure
//  resp_rdata  out  32  extended load data; 0 for stores/errors
//  resp_err    out  1   valid with resp_valid: illegal size, misalignment (or out-of-range, see CONFIGURATION)
//  mem_read    out  1   to bank memread
//  mem_write   out  1   to bank memwrite
//  mem_addr    out  32  word index = {2'b00, req_addr[31:2]}
//  mem_wdata   out  32  to bank writedata
//  mem_rdata   in   32  from bank readdata
// BEHAVIOUR
//  Reset: asynchronous on rst_n low; state IDLE; req_ready=1; all other outputs 0. Reset mid-transaction drops strobes at once; no resp.
//  States: IDLE, RD, GAP, WR, RESP. req_ready=1 only in IDLE. Request captured on accept.
//  Accept error check: size 11, half with addr[0]=1, word with addr[1:0]!=0 -> RESP with resp_err=1; no strobe asserted.
//  Load: IDLE->RD; mem_read=1 for MEM_LAT+1 cycles; mem_rdata sampled on last RD edge -> RESP.
//  Lane select by addr[1:0] (little-endian); extend per req_signed. resp_valid MEM_LAT+2 cycles after accept edge.
//  Word store: IDLE->WR; mem_write=1 for MEM_LAT+1 cycles with mem_wdata=req_wdata -> RESP.
//  Sub-word store: RD (as load) -> GAP (1 cycle, both strobes 0) -> WR with merged word (only addressed lanes replaced) -> RESP.
//  Invariant: mem_read & mem_write never both 1. mem_addr/mem_wdata stable whenever a strobe is high and through GAP.
//  RESP: resp_valid=1 for exactly one cycle -> IDLE. New request may be accepted the following cycle.
//  Strobes and mem_wdata return to 0 in IDLE/RESP; mem_addr holds last value.
//  Counter for MEM_LAT is $clog2(MEM_LAT+1) bits, cleared on every state entry.
// CONFIGURATION
//  DMEM_BOUNDS_CHECK_EN defined: word index >= DEPTH_WORDS flags resp_err at accept; no strobe; resp_rdata=0.
//  Undefined: no range check; address passed to bank unmodified.
// STRUCTURE
//  Package dmem_pkg: size enum (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_BAD), state enum, DATA_W constant.
//  Sub-module dmem_lane_align (combinational): load extract/extend and store merge from addr[1:0], size, signed.
//  FSM, latency counter and request capture stay in dmem_access_ctrl.
// TESTING
//  Word store addr 0x10 data 0xDEADBEEF, MEM_LAT=1: mem_write high 2 cycles at mem_addr 4; resp_valid pulse, resp_err=0.
//  Word load addr 0x10: mem_read high 2 cycles; resp_rdata=0xDEADBEEF exactly 3 cycles after accept.
//  Signed byte load addr 0x13 -> 0xFFFFFFDE; unsigned half load addr 0x12 -> 0x0000DEAD.
//  Byte store 0x55 to addr 0x11: read, 1-cycle gap, write 0xDEAD55EF; never both strobes high.
//  Half load addr 0x11 and size 11: resp_err=1 next cycle; no strobe ever asserted.
//  rst_n low during WR of RMW: strobes 0 immediately, no resp_valid, req_ready=1; with DMEM_BOUNDS_CHECK_EN, addr 0x200 -> resp_err=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access controller.
package dmem_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_GAP,
        S_WR,
        S_RESP
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module dmem_lane_align #(
    parameter int DATA_W = dmem_pkg::DATA_W
) (
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] rword,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] st_word
);
    import dmem_pkg::*;

    logic [4:0]        sh;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;

    always_comb begin
        sh      = {addr_lo, 3'b000};
        shifted = rword >> sh;
        ld_data = rword;
        mask    = '1;
        case (size_e'(size))
            SZ_BYTE: begin
                ld_data = is_signed ? {{(DATA_W-8){shifted[7]}}, shifted[7:0]}
                                    : {{(DATA_W-8){1'b0}}, shifted[7:0]};
                mask    = DATA_W'(8'hFF) << sh;
            end
            SZ_HALF: begin
                ld_data = is_signed ? {{(DATA_W-16){shifted[15]}}, shifted[15:0]}
                                    : {{(DATA_W-16){1'b0}}, shifted[15:0]};
                mask    = DATA_W'(16'hFFFF) << sh;
            end
            default: ;
        endcase
        // Word size leaves mask all-ones, so the merge degenerates to wdata.
        st_word = (rword & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for a 128-word strobe-level bank, with sub-word RMW.
// Optional range check enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_access_ctrl #(
    parameter int DATA_W      = dmem_pkg::DATA_W,
    parameter int DEPTH_WORDS = 128,
    parameter int MEM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import dmem_pkg::*;

    localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT);
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    size_e             size_q, size_d;
    logic              signed_q, signed_d;
    logic              err_q, err_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              acc_err;
    logic              lat_done;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_word;

    always_comb begin
        acc_err = 1'b0;
        case (size_e'(req_size))
            SZ_HALF: acc_err = req_addr[0];
            SZ_WORD: acc_err = (req_addr[1:0] != 2'b00);
            SZ_BAD:  acc_err = 1'b1;
            default: ;
        endcase
        if (BOUNDS_EN && (req_addr[31:2] >= 30'(DEPTH_WORDS)))
            acc_err = 1'b1;
    end

    assign lat_done = (cnt_q == LAT_LAST);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                we_d     = req_we;
                size_d   = size_e'(req_size);
                signed_d = req_signed;
                err_d    = acc_err;
                addr_d   = req_addr;
                wdata_d  = req_wdata;
                if (acc_err)
                    state_d = S_RESP;
                else if (req_we && size_e'(req_size) == SZ_WORD)
                    state_d = S_WR;
                else
                    state_d = S_RD;
            end
            S_RD: if (lat_done) begin
                rdata_d = mem_rdata;
                state_d = we_q ? S_GAP : S_RESP;
            end
            S_GAP:   state_d = S_WR;
            S_WR:    if (lat_done) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Counter restarts on every state change; it only advances while a strobe is held.
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == S_RD || state_q == S_WR)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    dmem_lane_align #(.DATA_W(DATA_W)) u_align (
        .addr_lo   (addr_q[1:0]),
        .size      (size_q),
        .is_signed (signed_q),
        .rword     (rdata_q),
        .wdata     (wdata_q),
        .ld_data   (ld_data),
        .st_word   (st_word)
    );

    // All outputs decode from registered state, so they stay glitch-free and stable per state.
    assign req_ready  = (state_q == S_IDLE);
    assign mem_read   = (state_q == S_RD);
    assign mem_write  = (state_q == S_WR);
    assign mem_addr   = {2'b00, addr_q[31:2]};
    assign mem_wdata  = (state_q == S_GAP || state_q == S_WR) ? st_word : '0;
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = (state_q == S_RESP && !err_q && !we_q) ? ld_data : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl against a simple strobe-level bank model.
module tb_dmem_access_ctrl;
    localparam int L = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.DATA_W(32), .DEPTH_WORDS(128), .MEM_LAT(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Bank model and protocol monitors
    logic [31:0] bank [0:127];
    int          rd_cyc = 0, wr_cyc = 0, both_hi = 0, direct = 0, resp_cnt = 0;
    logic        prev_rd = 1'b0;
    logic [31:0] last_wr_addr = '0, last_wr_data = '0;

    assign mem_rdata = mem_read ? bank[mem_addr[6:0]] : 32'h0;

    always @(posedge clk) begin
        prev_rd <= mem_read;
        if (mem_read)  rd_cyc <= rd_cyc + 1;
        if (mem_write) begin
            wr_cyc       <= wr_cyc + 1;
            bank[mem_addr[6:0]] <= mem_wdata;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end
        if (mem_read && mem_write) both_hi <= both_hi + 1;
        if (mem_write && prev_rd)  direct <= direct + 1;
        if (resp_valid)            resp_cnt <= resp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          lat, rd0, wr0, bh0, dr0, rc0;
    logic [31:0] rdat;
    logic        rerr;

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        rd0 = rd_cyc; wr0 = wr_cyc; bh0 = both_hi; dr0 = direct;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdat = resp_rdata;
        rerr = resp_err;
    endtask

    initial begin
        int cyc;

        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_strobes", {mem_read, mem_write}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        rst_n = 1'b1;

        // Word store 0x10 <- DEADBEEF
        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
        check("sw_lat", lat, L + 2);
        check("sw_err", rerr, 0);
        check("sw_rdata", rdat, 0);
        check("sw_wr_cyc", wr_cyc - wr0, L + 1);
        check("sw_rd_cyc", rd_cyc - rd0, 0);
        check("sw_addr", last_wr_addr, 32'd4);
        check("sw_data", last_wr_data, 32'hDEADBEEF);

        issue(0, 2'b10, 0, 32'h10, 0);
        check("lw_lat", lat, L + 2);
        check("lw_data", rdat, 32'hDEADBEEF);
        check("lw_rd_cyc", rd_cyc - rd0, L + 1);
        check("lw_wr_cyc", wr_cyc - wr0, 0);

        issue(0, 2'b00, 1, 32'h13, 0);
        check("lb_s_13", rdat, 32'hFFFFFFDE);
        issue(0, 2'b01, 0, 32'h12, 0);
        check("lhu_12", rdat, 32'h0000DEAD);
        issue(0, 2'b01, 1, 32'h12, 0);
        check("lh_s_12", rdat, 32'hFFFFDEAD);
        issue(0, 2'b00, 0, 32'h10, 0);
        check("lbu_10", rdat, 32'h000000EF);
        issue(0, 2'b00, 1, 32'h10, 0);
        check("lb_s_10", rdat, 32'hFFFFFFEF);

        // Byte store RMW: read, gap, write merged word
        issue(1, 2'b00, 0, 32'h11, 32'hFFFFFF55);
        check("sb_lat", lat, 2 * L + 4);
        check("sb_err", rerr, 0);
        check("sb_rd_cyc", rd_cyc - rd0, L + 1);
        check("sb_wr_cyc", wr_cyc - wr0, L + 1);
        check("sb_data", last_wr_data, 32'hDEAD55EF);
        check("sb_both_hi", both_hi - bh0, 0);
        check("sb_no_gap", direct - dr0, 0);
        issue(0, 2'b10, 0, 32'h10, 0);
        check("sb_readback", rdat, 32'hDEAD55EF);

        issue(1, 2'b01, 0, 32'h12, 32'h1234CAFE);
        check("sh_data", last_wr_data, 32'hCAFE55EF);
        issue(0, 2'b10, 1, 32'h10, 0);
        check("sh_readback", rdat, 32'hCAFE55EF);

        // Error cases: no strobes, response on the next cycle
        issue(0, 2'b01, 0, 32'h11, 0);
        check("mis_half_err", rerr, 1);
        check("mis_half_lat", lat, 1);
        check("mis_half_rdata", rdat, 0);
        check("mis_half_strobes", (rd_cyc - rd0) + (wr_cyc - wr0), 0);
        issue(1, 2'b11, 0, 32'h10, 32'h12345678);
        check("bad_size_err", rerr, 1);
        check("bad_size_lat", lat, 1);
        check("bad_size_strobes", (rd_cyc - rd0) + (wr_cyc - wr0), 0);
        issue(0, 2'b10, 0, 32'h12, 0);
        check("mis_word_err", rerr, 1);
        check("mis_word_strobes", (rd_cyc - rd0) + (wr_cyc - wr0), 0);

        // Reset during the WR phase of an RMW
        issue(1, 2'b10, 0, 32'h20, 32'h01234567);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h000000AA;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!mem_write && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_wr_reached", mem_write, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {mem_read, mem_write}, 0);
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_wdata", mem_wdata, 0);
        rc0 = resp_cnt;
        repeat (3) @(negedge clk);
        check("rst_mid_no_resp", resp_cnt - rc0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_after_no_resp", resp_cnt - rc0, 0);
        issue(0, 2'b10, 0, 32'h20, 0);
        check("rst_word_intact", rdat, 32'h01234567);
        check("rst_word_err", rerr, 0);

`ifdef DMEM_BOUNDS_CHECK_EN
        issue(0, 2'b10, 0, 32'h200, 0);
        check("oob_err", rerr, 1);
        check("oob_rdata", rdat, 0);
        check("oob_strobes", (rd_cyc - rd0) + (wr_cyc - wr0), 0);
        issue(1, 2'b10, 0, 32'h1FC, 32'h0BADF00D);
        check("top_word_err", rerr, 0);
        issue(0, 2'b10, 0, 32'h1FC, 0);
        check("top_word_data", rdat, 32'h0BADF00D);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
